// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist
// Power-on self-test sequencer for the execute-stage ALU. A start request
// walks a fixed 9-entry operation table through the ALU input mux, holds each
// vector for SETTLE_CYCLES, then compares the full-width ALU result with the
// stored expectation. Reports pass/fail, a saturating failure count and the
// index/result/status seen at the first miscompare.
//
// Ports
//   clk             clock, all state on rising edge
//   rst_n           synchronous active-low reset
//   i_Start         start request (honoured only in IDLE or DONE)
//   o_A, o_B        ALU operands (held after the run)
//   o_Sigs_Control  ALU opcode
//   o_Sig_Carry_In  ALU carry/borrow in
//   i_ALU_Result    ALU result under test
//   i_Status        ALU flags, captured at the first failure only
//   o_Busy          run in progress
//   o_Done          run finished, held until the next accepted start
//   o_Pass          o_Done with zero failures
//   o_Fail_Count    miscompares in this run, saturating at 15
//   o_Fail_Index    first failing vector index
//   o_Fail_Result   i_ALU_Result at the first failure
//   o_Fail_Status   i_Status at the first failure
// DATA_WIDTH below 32 is not supported; table entries are zero-extended.
// -----------------------------------------------------------------------------
module alu_bist #(
   parameter int DATA_WIDTH    = 32,
   parameter int SETTLE_CYCLES = 1,
   parameter bit STOP_ON_FAIL  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_Start,
   output logic [DATA_WIDTH-1:0] o_A,
   output logic [DATA_WIDTH-1:0] o_B,
   output logic [3:0]            o_Sigs_Control,
   output logic                  o_Sig_Carry_In,
   input  logic [DATA_WIDTH-1:0] i_ALU_Result,
   input  logic [3:0]            i_Status,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_Pass,
   output logic [3:0]            o_Fail_Count,
   output logic [3:0]            o_Fail_Index,
   output logic [DATA_WIDTH-1:0] o_Fail_Result,
   output logic [3:0]            o_Fail_Status
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] exp;
   } vec_t;

   localparam logic [3:0] LAST_IDX = 4'd8;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   // Fixed self-test table; out-of-range indices return an all-zero entry.
   function automatic vec_t vec_lookup(input logic [3:0] idx);
      vec_t v;
      case (idx)
         4'd0:    v = '{4'b0001, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h5555_5555};
         4'd1:    v = '{4'b1001, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hAAAA_AAAA};
         4'd2:    v = '{4'b0010, 32'h0000_00A5, 32'h0000_005A, 1'b0, 32'h0000_00FF};
         4'd3:    v = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001};
         4'd4:    v = '{4'b0100, 32'h0000_00FF, 32'h0000_00A5, 1'b0, 32'h0000_005A};
         4'd5:    v = '{4'b0101, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE};
         4'd6:    v = '{4'b0110, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 32'h0000_FFFF};
         4'd7:    v = '{4'b0111, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'hFFFF_FFFF};
         4'd8:    v = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 32'hFFFF_0000};
         default: v = '0;
      endcase
      return v;
   endfunction

   state_t                state_q;
   logic [3:0]            index_q;
   logic [3:0]            settle_cnt_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [3:0]            ctrl_q;
   logic                  cin_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  pass_q;
   logic [3:0]            fail_count_q;
   logic [3:0]            fail_index_q;
   logic [DATA_WIDTH-1:0] fail_result_q;
   logic [3:0]            fail_status_q;

   vec_t                  vec_s;
   logic [DATA_WIDTH-1:0] exp_s;
   logic                  mismatch_s;
   logic                  last_s;

   // Current vector decode and result compare for the CHECK state.
   always_comb begin
      vec_s      = vec_lookup(index_q);
      exp_s      = DATA_WIDTH'(vec_s.exp);
      mismatch_s = (i_ALU_Result != exp_s);
      last_s     = (index_q == LAST_IDX);
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         index_q       <= 4'd0;
         settle_cnt_q  <= 4'd0;
         a_q           <= '0;
         b_q           <= '0;
         ctrl_q        <= 4'd0;
         cin_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_count_q  <= 4'd0;
         fail_index_q  <= 4'd0;
         fail_result_q <= '0;
         fail_status_q <= 4'd0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (i_Start) begin
                  state_q       <= ST_ISSUE;
                  index_q       <= 4'd0;
                  busy_q        <= 1'b1;
                  done_q        <= 1'b0;
                  pass_q        <= 1'b0;
                  fail_count_q  <= 4'd0;
                  fail_index_q  <= 4'd0;
                  fail_result_q <= '0;
                  fail_status_q <= 4'd0;
               end else begin
                  state_q <= state_q;
               end
            end
            ST_ISSUE: begin
               a_q          <= DATA_WIDTH'(vec_s.a);
               b_q          <= DATA_WIDTH'(vec_s.b);
               ctrl_q       <= vec_s.ctrl;
               cin_q        <= vec_s.cin;
               settle_cnt_q <= SETTLE_LOAD;
               state_q      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_cnt_q == 4'd0) begin
                  state_q <= ST_CHECK;
               end else begin
                  settle_cnt_q <= settle_cnt_q - 4'd1;
               end
            end
            ST_CHECK: begin
               if (mismatch_s) begin
                  if (fail_count_q != 4'd15) begin
                     fail_count_q <= fail_count_q + 4'd1;
                  end
                  // Count is still zero only on the first miscompare of the run.
                  if (fail_count_q == 4'd0) begin
                     fail_index_q  <= index_q;
                     fail_result_q <= i_ALU_Result;
                     fail_status_q <= i_Status;
                  end
               end
               if (last_s || (mismatch_s && STOP_ON_FAIL)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (fail_count_q == 4'd0) && !mismatch_s;
               end else begin
                  index_q <= index_q + 4'd1;
                  state_q <= ST_ISSUE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_A            = a_q;
   assign o_B            = b_q;
   assign o_Sigs_Control = ctrl_q;
   assign o_Sig_Carry_In = cin_q;
   assign o_Busy         = busy_q;
   assign o_Done         = done_q;
   assign o_Pass         = pass_q;
   assign o_Fail_Count   = fail_count_q;
   assign o_Fail_Index   = fail_index_q;
   assign o_Fail_Result  = fail_result_q;
   assign o_Fail_Status  = fail_status_q;

endmodule
